// File: rtl/ex_seq_pkg.sv
// Shared types for the execute-block self-test sequencer: operator encodings,
// the vector record, the table size and the sequencer state enum.
// The operator encodings match ibex_pkg so the sequencer outputs connect
// straight to ibex_ex_block.
package ex_seq_pkg;

  typedef enum logic [6:0] {
    ALU_ADD = 7'd0,
    ALU_SUB = 7'd1,
    ALU_XOR = 7'd2,
    ALU_OR  = 7'd3,
    ALU_AND = 7'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef struct packed {
    logic        is_mult;
    alu_op_e     alu_op;
    md_op_e      md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } ex_vec_t;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } ex_seq_state_e;

endpackage

// File: rtl/ex_vec_rom.sv
// Fixed self-test vector table: combinational index -> vector lookup.
module ex_vec_rom
  import ex_seq_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output ex_vec_t          vec_o
);

  // Table lookup; unused fields default to zero / ALU_ADD / MD_OP_MULL.
  always_comb begin
    vec_o         = '0;
    vec_o.alu_op  = ALU_ADD;
    vec_o.md_op   = MD_OP_MULL;
    case (idx_i)
      3'd0: begin vec_o.alu_op = ALU_ADD; vec_o.a = 32'd15;        vec_o.b = 32'd25;        vec_o.exp = 32'd40;        end
      3'd1: begin vec_o.alu_op = ALU_SUB; vec_o.a = 32'd100;       vec_o.b = 32'd30;        vec_o.exp = 32'd70;        end
      3'd2: begin vec_o.alu_op = ALU_AND; vec_o.a = 32'h0000_FF00; vec_o.b = 32'h0000_0FF0; vec_o.exp = 32'h0000_0F00; end
      3'd3: begin vec_o.alu_op = ALU_OR;  vec_o.a = 32'h0000_F000; vec_o.b = 32'h0000_000F; vec_o.exp = 32'h0000_F00F; end
      3'd4: begin vec_o.alu_op = ALU_XOR; vec_o.a = 32'hAAAA_AAAA; vec_o.b = 32'h5555_5555; vec_o.exp = 32'hFFFF_FFFF; end
      3'd5: begin vec_o.is_mult = 1'b1;   vec_o.a = 32'd12;        vec_o.b = 32'd12;        vec_o.exp = 32'd144;       end
      3'd6: begin vec_o.is_mult = 1'b1;   vec_o.a = 32'd1000;      vec_o.b = 32'd500;       vec_o.exp = 32'd500000;    end
      3'd7: begin vec_o.is_mult = 1'b1;   vec_o.a = 32'hFFFF_FFFF; vec_o.b = 32'd2;         vec_o.exp = 32'hFFFF_FFFE; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_selftest_seq.sv
// Autonomous self-test sequencer for ibex_ex_block. Walks the vector table,
// drives operands, waits for ex_valid under a timeout, compares the result
// and reports pass/fail. Also owns the IMD loopback registers.
// Build option: EX_SEQ_STOP_ON_FAIL_EN ends the run at the first failing vector.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a start_i rising edge
// S_ISSUE | load current vector onto operand outputs, arm timeout
// S_WAIT  | operands held; wait for ex_valid_i or timeout
// S_CHECK | compare captured result, update failure status
// S_DONE  | one-cycle done pulse, latch pass; loop or go idle
module ex_selftest_seq
  import ex_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             loop_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [2:0]       fail_idx_o,
  output logic [6:0]       alu_operator_o,
  output logic [31:0]      alu_operand_a_o,
  output logic [31:0]      alu_operand_b_o,
  output logic             mult_sel_o,
  output logic             div_sel_o,
  output logic             div_en_o,
  output logic [1:0]       multdiv_operator_o,
  output logic [1:0]       multdiv_signed_mode_o,
  output logic [31:0]      multdiv_operand_a_o,
  output logic [31:0]      multdiv_operand_b_o,
  input  logic             ex_valid_i,
  input  logic [31:0]      result_ex_i,
  input  logic [31:0]      imd_val_d_i [2],
  input  logic [1:0]       imd_val_we_i,
  output logic [31:0]      imd_val_q_o [2]
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  ex_seq_state_e    r_state, w_state_d;
  logic             r_start_q;
  logic             w_start_rise;
  logic [IDX_W-1:0] r_idx;
  logic [TMR_W-1:0] r_tmr;
  logic [31:0]      r_result;
  logic             r_vec_to;
  logic             r_first_fail;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [2:0]       r_fail_idx;
  logic             r_pass;
  logic             r_timeout;
  alu_op_e          r_alu_op;
  logic [31:0]      r_alu_a, r_alu_b;
  logic             r_mult_sel;
  md_op_e           r_md_op;
  logic [31:0]      r_md_a, r_md_b;
  logic [31:0]      r_imd_q [2];

  ex_vec_t          w_vec;
  logic             w_fail, w_last, w_stop;
  logic             w_busy, w_done, w_clear, w_capture, w_to_hit, w_tmr_dec, w_idx_inc;

  ex_vec_rom u_rom (
    .idx_i (r_idx),
    .vec_o (w_vec)
  );

  assign w_start_rise = start_i & ~r_start_q;
  // A timed-out vector fails regardless of whatever stale result is held.
  assign w_fail       = r_vec_to | (r_result != w_vec.exp);
  assign w_last       = (r_idx == IDX_W'(NUM_VEC - 1));
`ifdef EX_SEQ_STOP_ON_FAIL_EN
  assign w_stop       = w_last | w_fail;
`else
  assign w_stop       = w_last;
`endif

  // Registered copy of start_i for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_start_q <= 1'b0;
    else         r_start_q <= start_i;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_d;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    w_state_d = r_state;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_clear   = 1'b0;
    w_capture = 1'b0;
    w_to_hit  = 1'b0;
    w_tmr_dec = 1'b0;
    w_idx_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_d = S_ISSUE;
          w_clear   = 1'b1;
        end
      end
      S_ISSUE: begin
        w_busy    = 1'b1;
        w_state_d = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        // valid takes priority over an expiring timer in the same cycle
        if (ex_valid_i) begin
          w_capture = 1'b1;
          w_state_d = S_CHECK;
        end else if (r_tmr == '0) begin
          w_to_hit  = 1'b1;
          w_state_d = S_CHECK;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      S_CHECK: begin
        w_busy = 1'b1;
        if (w_stop) begin
          w_state_d = S_DONE;
        end else begin
          w_idx_inc = 1'b1;
          w_state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (loop_i) begin
          w_state_d = S_ISSUE;
          w_clear   = 1'b1;
        end else begin
          w_state_d = S_IDLE;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  // Vector index, timeout down-counter, result capture and run status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx        <= '0;
      r_tmr        <= '0;
      r_result     <= '0;
      r_vec_to     <= 1'b0;
      r_first_fail <= 1'b0;
      r_fail_cnt   <= '0;
      r_fail_idx   <= '0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_clear) begin
        r_idx        <= '0;
        r_fail_cnt   <= '0;
        r_timeout    <= 1'b0;
        r_first_fail <= 1'b0;
      end
      if (w_idx_inc) r_idx <= r_idx + IDX_W'(1);
      if (r_state == S_ISSUE) begin
        r_tmr    <= TMR_LOAD;
        r_vec_to <= 1'b0;
      end
      if (w_tmr_dec) r_tmr <= r_tmr - TMR_W'(1);
      if (w_capture) r_result <= result_ex_i;
      if (w_to_hit) begin
        r_vec_to  <= 1'b1;
        r_timeout <= 1'b1;
      end
      if (r_state == S_CHECK && w_fail) begin
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        if (!r_first_fail) begin
          r_fail_idx   <= r_idx;
          r_first_fail <= 1'b1;
        end
      end
      if (r_state == S_DONE) r_pass <= (r_fail_cnt == '0);
    end
  end

  // Operand and select outputs: loaded in ISSUE, held through WAIT,
  // multiplier select dropped as WAIT exits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alu_op   <= ALU_ADD;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_mult_sel <= 1'b0;
      r_md_op    <= MD_OP_MULL;
      r_md_a     <= '0;
      r_md_b     <= '0;
    end else if (r_state == S_ISSUE) begin
      if (w_vec.is_mult) begin
        r_alu_op   <= ALU_ADD;
        r_alu_a    <= '0;
        r_alu_b    <= '0;
        r_mult_sel <= 1'b1;
        r_md_op    <= w_vec.md_op;
        r_md_a     <= w_vec.a;
        r_md_b     <= w_vec.b;
      end else begin
        r_alu_op   <= w_vec.alu_op;
        r_alu_a    <= w_vec.a;
        r_alu_b    <= w_vec.b;
        r_mult_sel <= 1'b0;
        r_md_op    <= MD_OP_MULL;
        r_md_a     <= '0;
        r_md_b     <= '0;
      end
    end else if (w_capture || w_to_hit) begin
      r_mult_sel <= 1'b0;
    end
  end

  // IMD loopback for the multi-cycle multiplier, active in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) r_imd_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (imd_val_we_i[i]) r_imd_q[i] <= imd_val_d_i[i];
      end
    end
  end

  assign busy_o                = w_busy;
  assign done_o                = w_done;
  assign pass_o                = r_pass;
  assign timeout_o             = r_timeout;
  assign fail_cnt_o            = r_fail_cnt;
  assign fail_idx_o            = r_fail_idx;
  assign alu_operator_o        = r_alu_op;
  assign alu_operand_a_o       = r_alu_a;
  assign alu_operand_b_o       = r_alu_b;
  assign mult_sel_o            = r_mult_sel;
  assign div_sel_o             = 1'b0;
  assign div_en_o              = 1'b0;
  assign multdiv_operator_o    = r_md_op;
  assign multdiv_signed_mode_o = 2'b00;
  assign multdiv_operand_a_o   = r_md_a;
  assign multdiv_operand_b_o   = r_md_b;
  assign imd_val_q_o           = r_imd_q;

endmodule

// File: tb/tb_ex_selftest_seq.sv
// Bench for ex_selftest_seq: a behavioural execute-block stand-in answers the
// sequencer, stimulus pushes the expected end-of-run status into a queue and
// a monitor pops and compares it on every done_o pulse.
module tb_ex_selftest_seq;
  import ex_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0, loop_i = 1'b0;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [7:0]  fail_cnt_o;
  logic [2:0]  fail_idx_o;
  logic [6:0]  alu_operator_o;
  logic [31:0] alu_operand_a_o, alu_operand_b_o;
  logic        mult_sel_o, div_sel_o, div_en_o;
  logic [1:0]  multdiv_operator_o, multdiv_signed_mode_o;
  logic [31:0] multdiv_operand_a_o, multdiv_operand_b_o;
  logic        ex_valid_i = 1'b0;
  logic [31:0] result_ex_i = '0;
  logic [31:0] imd_val_d_i [2];
  logic [1:0]  imd_val_we_i = 2'b00;
  logic [31:0] imd_val_q_o [2];

  always #5 clk_i = ~clk_i;

  ex_selftest_seq #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .loop_i(loop_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .fail_cnt_o(fail_cnt_o), .fail_idx_o(fail_idx_o),
    .alu_operator_o(alu_operator_o), .alu_operand_a_o(alu_operand_a_o),
    .alu_operand_b_o(alu_operand_b_o), .mult_sel_o(mult_sel_o),
    .div_sel_o(div_sel_o), .div_en_o(div_en_o),
    .multdiv_operator_o(multdiv_operator_o), .multdiv_signed_mode_o(multdiv_signed_mode_o),
    .multdiv_operand_a_o(multdiv_operand_a_o), .multdiv_operand_b_o(multdiv_operand_b_o),
    .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
    .imd_val_d_i(imd_val_d_i), .imd_val_we_i(imd_val_we_i), .imd_val_q_o(imd_val_q_o)
  );

  typedef struct { int cnt; int idx; bit to; bit pass; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0, done_seen = 0;
  logic [7:0] corrupt_m = 8'h00, stall_m = 8'h00;
  int mcnt = 0, streak = 0, streak_idx = -1, busy_cycles = 0;
  int streak_len [8];
  bit in_loop = 1'b0;
  int loop_dones = 0, loop_viol = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Identify the table entry from its unique operand a.
  function automatic int vidx(logic ms, logic [31:0] aa, logic [31:0] ma);
    if (ms) begin
      case (ma)
        32'd12: return 5;
        32'd1000: return 6;
        32'hFFFF_FFFF: return 7;
        default: return -1;
      endcase
    end
    case (aa)
      32'd15: return 0;
      32'd100: return 1;
      32'h0000_FF00: return 2;
      32'h0000_F000: return 3;
      32'hAAAA_AAAA: return 4;
      default: return -1;
    endcase
  endfunction

  // Execute-block stand-in (ALU valid at once, multiplier valid on its 3rd
  // cycle) plus WAIT-length, busy and loop bookkeeping.
  always @(negedge clk_i) begin
    int k;
    logic [31:0] r;
    if (mult_sel_o) begin
      mcnt++;
      k = vidx(1'b1, '0, multdiv_operand_a_o);
      r = multdiv_operand_a_o * multdiv_operand_b_o;
      ex_valid_i = (mcnt >= 3);
    end else begin
      mcnt = 0;
      k = vidx(1'b0, alu_operand_a_o, '0);
      case (alu_operator_o)
        ALU_ADD: r = alu_operand_a_o + alu_operand_b_o;
        ALU_SUB: r = alu_operand_a_o - alu_operand_b_o;
        ALU_AND: r = alu_operand_a_o & alu_operand_b_o;
        ALU_OR:  r = alu_operand_a_o | alu_operand_b_o;
        ALU_XOR: r = alu_operand_a_o ^ alu_operand_b_o;
        default: r = '0;
      endcase
      ex_valid_i = 1'b1;
    end
    if (k >= 0) begin
      if (stall_m[k]) ex_valid_i = 1'b0;
      if (corrupt_m[k]) r = r ^ 32'd1;
    end
    result_ex_i = r;
    if (mult_sel_o) begin
      streak++;
      streak_idx = k;
    end else if (streak > 0) begin
      if (streak_idx >= 0) streak_len[streak_idx] = streak;
      streak = 0;
    end
    if (busy_o) busy_cycles++;
    if (in_loop) begin
      if (done_o) loop_dones++;
      else if (!busy_o && loop_dones < 3) loop_viol++;
    end
  end

  // Monitor: every done pulse pops one expected status.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && done_o) begin
        done_seen++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("fail_cnt", 32'(fail_cnt_o), 32'(e.cnt));
          chk("fail_idx", 32'(fail_idx_o), 32'(e.idx));
          chk("timeout", 32'(timeout_o), 32'(e.to));
          @(negedge clk_i);
          chk("pass", 32'(pass_o), 32'(e.pass));
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(2);
    start_i = 1'b0;
  endtask

  task automatic wait_dones(int target, int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (done_seen < target) begin
      errors++;
      $display("FAIL done_wait actual=%0d required=%0d", done_seen, target);
    end
    tick(3);
  endtask

  initial begin
    int n;
    int base;
    imd_val_d_i[0] = '0;
    imd_val_d_i[1] = '0;
    #2 rst_ni = 1'b0;
    tick(3);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_pass", 32'(pass_o), 0);
    chk("rst_alu_op", 32'(alu_operator_o), 32'(ALU_ADD));
    chk("rst_md_op", 32'(multdiv_operator_o), 32'(MD_OP_MULL));
    chk("rst_fail_cnt", 32'(fail_cnt_o), 0);
    chk("rst_mult_sel", 32'(mult_sel_o), 0);
    chk("rst_imd0", imd_val_q_o[0], 0);
    rst_ni = 1'b1;
    tick(2);

    // IMD loopback, per-lane write enables
    imd_val_d_i[0] = 32'h1234_5678;
    imd_val_d_i[1] = 32'hCAFE_F00D;
    imd_val_we_i = 2'b01;
    tick(1);
    chk("imd0_wr", imd_val_q_o[0], 32'h1234_5678);
    chk("imd1_nowr", imd_val_q_o[1], 0);
    imd_val_d_i[0] = 32'h0000_DEAD;
    imd_val_we_i = 2'b10;
    tick(1);
    chk("imd0_hold", imd_val_q_o[0], 32'h1234_5678);
    chk("imd1_wr", imd_val_q_o[1], 32'hCAFE_F00D);
    imd_val_we_i = 2'b00;
    imd_val_d_i[1] = '0;
    tick(1);
    chk("imd1_hold", imd_val_q_o[1], 32'hCAFE_F00D);

    // clean run; a second start edge while busy must be ignored
    q.push_back('{0, 0, 1'b0, 1'b1});
    busy_cycles = 0;
    pulse_start();
    tick(5);
    start_i = 1'b1;
    tick(2);
    start_i = 1'b0;
    wait_dones(1, 400);
    chk("busy_cycles", busy_cycles, 30);
    chk("wait_len_v6", streak_len[6], 3);

    // corrupted result on vector 0
    corrupt_m = 8'h01;
    q.push_back('{1, 0, 1'b0, 1'b0});
    pulse_start();
    wait_dones(2, 400);
    corrupt_m = 8'h00;

    // timeout on vector 5
    stall_m = 8'h20;
    streak_len[5] = 0;
    q.push_back('{1, 5, 1'b1, 1'b0});
    pulse_start();
    wait_dones(3, 600);
    stall_m = 8'h00;
    chk("wait_len_v5", streak_len[5], 64);

    // failures at vectors 2 and 6
    corrupt_m = 8'h44;
`ifdef EX_SEQ_STOP_ON_FAIL_EN
    q.push_back('{1, 2, 1'b0, 1'b0});
`else
    q.push_back('{2, 2, 1'b0, 1'b0});
`endif
    pulse_start();
    wait_dones(4, 400);
    corrupt_m = 8'h00;

    // loop mode, three clean runs
    repeat (3) q.push_back('{0, 2, 1'b0, 1'b1});
    loop_i = 1'b1;
    loop_dones = 0;
    loop_viol = 0;
    pulse_start();
    in_loop = 1'b1;
    wait_dones(6, 400);
    loop_i = 1'b0;
    wait_dones(7, 400);
    in_loop = 1'b0;
    chk("loop_dones", loop_dones, 3);
    chk("loop_busy_gap", loop_viol, 0);

    // reset during vector 3 WAIT, with a start edge presented during reset
    corrupt_m = 8'h01;
    base = done_seen;
    pulse_start();
    n = 0;
    while (!(busy_o && alu_operand_a_o == 32'h0000_F000) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_v3", 32'(n < 200), 1);
    rst_ni = 1'b0;
    start_i = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_fail_cnt", 32'(fail_cnt_o), 0);
    chk("mrst_pass", 32'(pass_o), 0);
    chk("mrst_alu_a", alu_operand_a_o, 0);
    chk("mrst_imd0", imd_val_q_o[0], 0);
    tick(3);
    chk("mrst_start_ignored", 32'(busy_o), 0);
    start_i = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    corrupt_m = 8'h00;
    tick(40);
    chk("mrst_no_done", done_seen, base);
    chk("mrst_idle", 32'(busy_o), 0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
